// File: rtl/fft_frame_unpacker.sv
// Pairs the real/imag lane beats from the FFT core into a two-slot ping-pong
// buffer and replays each frame as a serial complex stream under valid/ready.
module fft_frame_unpacker #(
    parameter  int NPT    = 16,
    parameter  int DW     = 16,
    parameter  int NFRAME = 64,
    localparam int IW     = $clog2(NPT),
    localparam int CW     = $clog2(NFRAME) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fft_valid,
    input  logic [DW-1:0] fft_d0,
    input  logic [DW-1:0] fft_d1,
    input  logic [DW-1:0] fft_d2,
    input  logic [DW-1:0] fft_d3,
    input  logic [DW-1:0] fft_d4,
    input  logic [DW-1:0] fft_d5,
    input  logic [DW-1:0] fft_d6,
    input  logic [DW-1:0] fft_d7,
    input  logic [DW-1:0] fft_d8,
    input  logic [DW-1:0] fft_d9,
    input  logic [DW-1:0] fft_d10,
    input  logic [DW-1:0] fft_d11,
    input  logic [DW-1:0] fft_d12,
    input  logic [DW-1:0] fft_d13,
    input  logic [DW-1:0] fft_d14,
    input  logic [DW-1:0] fft_d15,
    input  logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic [CW-1:0] frame_cnt,
    output logic          overflow,
    output logic          all_done
);

    typedef enum logic [1:0] {
        CAP_REAL,
        CAP_IMAG,
        CAP_DROP
    } cap_t;

    typedef enum logic {
        O_IDLE,
        O_SEND
    } ost_t;

    logic [DW-1:0] lane [NPT];

    assign lane[0]  = fft_d0;
    assign lane[1]  = fft_d1;
    assign lane[2]  = fft_d2;
    assign lane[3]  = fft_d3;
    assign lane[4]  = fft_d4;
    assign lane[5]  = fft_d5;
    assign lane[6]  = fft_d6;
    assign lane[7]  = fft_d7;
    assign lane[8]  = fft_d8;
    assign lane[9]  = fft_d9;
    assign lane[10] = fft_d10;
    assign lane[11] = fft_d11;
    assign lane[12] = fft_d12;
    assign lane[13] = fft_d13;
    assign lane[14] = fft_d14;
    assign lane[15] = fft_d15;

    logic [DW-1:0] re_buf [2][NPT];
    logic [DW-1:0] im_buf [2][NPT];

    cap_t          phase;
    ost_t          ost;
    logic [1:0]    full;
    logic          wp;
    logic          rp;
    logic          done_seen;

    logic          cap_ok;
    logic          wr_re;
    logic          wr_im;
    logic          hs;
    logic          hs_last;
    logic          done_any;
    logic [IW-1:0] idx_nx;
    logic [1:0]    set_mask;
    logic [1:0]    clr_mask;
    logic          drained;

    assign cap_ok   = fft_valid && !all_done;
    assign wr_re    = cap_ok && (phase == CAP_REAL) && !full[wp];
    assign wr_im    = cap_ok && (phase == CAP_IMAG);
    assign hs       = out_valid && out_ready;
    assign hs_last  = hs && (out_idx == IW'(NPT - 1));
    assign done_any = done || done_seen;
    assign idx_nx   = out_idx + 1'b1;
    assign set_mask = {wr_im & wp, wr_im & ~wp};
    assign clr_mask = {hs_last & rp, hs_last & ~rp};
    assign drained  = (full == 2'b00) && (ost == O_IDLE)
                   && (phase == CAP_REAL);

    // Sample storage carries no reset; slot validity lives in full[].
    always_ff @(posedge clk) begin
        if (wr_re) begin
            for (int k = 0; k < NPT; k++) begin
                re_buf[wp][k] <= lane[k];
            end
        end
        if (wr_im) begin
            for (int k = 0; k < NPT; k++) begin
                im_buf[wp][k] <= lane[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= CAP_REAL;
            wp       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (phase)
                CAP_REAL: begin
                    if (cap_ok) begin
                        if (full[wp]) begin
                            overflow <= 1'b1;
                            phase    <= CAP_DROP;
                        end else begin
                            phase <= CAP_IMAG;
                        end
                    end
                end
                CAP_IMAG: begin
                    if (cap_ok) begin
                        wp    <= ~wp;
                        phase <= CAP_REAL;
                    end else if (done_any) begin
                        phase <= CAP_REAL;
                    end
                end
                CAP_DROP: begin
                    if (cap_ok || done_any) begin
                        phase <= CAP_REAL;
                    end
                end
                default: phase <= CAP_REAL;
            endcase
        end
    end

    // Fill and release may hit different slots in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ost       <= O_IDLE;
            rp        <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            unique case (ost)
                O_IDLE: begin
                    if (full[rp]) begin
                        ost       <= O_SEND;
                        out_valid <= 1'b1;
                        out_re    <= re_buf[rp][0];
                        out_im    <= im_buf[rp][0];
                        out_idx   <= '0;
                        out_last  <= (NPT == 1);
                    end
                end
                O_SEND: begin
                    if (hs_last) begin
                        rp      <= ~rp;
                        out_idx <= '0;
                        if (frame_cnt != CW'(NFRAME)) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        // Next slot already waiting: continue without a bubble.
                        if (full[~rp]) begin
                            out_re   <= re_buf[~rp][0];
                            out_im   <= im_buf[~rp][0];
                            out_last <= (NPT == 1);
                        end else begin
                            ost       <= O_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end else if (hs) begin
                        out_idx  <= idx_nx;
                        out_re   <= re_buf[rp][idx_nx];
                        out_im   <= im_buf[rp][idx_nx];
                        out_last <= (idx_nx == IW'(NPT - 1));
                    end
                end
                default: ost <= O_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_seen <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            done_seen <= done_seen | done;
            if ((done_seen && drained) || (frame_cnt == CW'(NFRAME))) begin
                all_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fft_frame_unpacker.md
Name: fft_frame_unpacker

Overview:
- Receive end of the FFT output interface. Accepts the 16-lane parallel FFT result bus (`fft_valid`, `fft_d0`..`fft_d15`), where each frame is one real beat followed by one imaginary beat.
- Pairs the two beats, holds them in a two-slot ping-pong buffer and replays each frame as a serial complex stream, one point per beat, under valid/ready handshake.
- Sits between the FFT core and downstream consumers (magnitude, memory writer).

Parameters:
- NPT, 16, points per frame = number of parallel lanes (power of 2).
- DW, 16, sample width (8 integer + 8 fraction, two's complement).
- NFRAME, 64, frames per run (1024 points / NPT); `all_done` after this many frames are emitted.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fft_valid  in  1  lane bus carries a beat this cycle.
- fft_d0..fft_d15  in  DW each  lane k = point k of the current beat.
- done  in  1  FFT core finished; no further beats follow.
- out_valid  out  1  `out_re`/`out_im`/`out_idx`/`out_last` valid.
- out_ready  in  1  consumer accepts the beat when `out_valid` and `out_ready` are both high.
- out_re  out  DW  real part of the current point.
- out_im  out  DW  imaginary part of the current point.
- out_idx  out  log2(NPT)  point index within the frame, 0..NPT-1.
- out_last  out  1  high with `out_idx` == NPT-1.
- frame_cnt  out  log2(NFRAME)+1  frames fully emitted.
- overflow  out  1  sticky: a frame was dropped because both slots were occupied.
- all_done  out  1  `frame_cnt` == NFRAME, or `done` seen and buffer drained.

Behaviour:
- Reset values: all outputs 0; both slots empty; capture phase = REAL; write pointer = 0; read pointer = 0; `out_idx` = 0.
- Capture phase REAL:
  - On `fft_valid`, latch all NPT lanes into `re[wp]` and go to IMAG.
  - If slot `wp` is full, set `overflow` sticky, enter DROP_IMAG and latch nothing.
- Capture phase IMAG:
  - On `fft_valid`, latch lanes into `im[wp]`, mark slot `wp` full, toggle `wp`, return to REAL.
- DROP_IMAG: the next `fft_valid` beat is discarded; return to REAL. Real/imag pairing stays aligned after a drop.
- Beats need not be back-to-back. Gaps of any length between real and imag beats, or between frames, are allowed.
- Output FSM has two states:
  - IDLE: `out_valid` = 0. Move to SEND when slot `rp` is full. Data is registered, so the first beat appears one cycle after the slot fills (2-cycle latency from the imag beat edge to `out_valid`).
  - SEND: `out_valid` = 1 and outputs show `re[rp][out_idx]` / `im[rp][out_idx]`. Outputs hold stable while `out_ready` = 0.
  - On handshake with `out_idx` < NPT-1: increment `out_idx`.
  - On handshake with `out_idx` == NPT-1: clear slot `rp`, toggle `rp`, reset `out_idx` to 0, increment `frame_cnt`. Then stay in SEND (no bubble) if the other slot is already full; otherwise go to IDLE.
- Simultaneous capture-completion into slot X and release of slot Y (X ≠ Y) in the same cycle: both take effect.
- A slot freed in cycle t may be written by a real beat in cycle t+1, not in cycle t. The full check uses the registered flag.
- `done` is latched sticky.
  - `all_done` asserts when `done_seen` is set, both slots are empty, the output FSM is IDLE, and capture phase is REAL.
  - `all_done` also asserts when `frame_cnt` reaches NFRAME.
  - Once high, `all_done` holds until reset. Beats arriving after `all_done` are ignored.
- A dangling real beat when `done` arrives (phase IMAG) is discarded: phase returns to REAL, and `overflow` is not set.
- Reset asserted mid-frame: immediate return to reset state; partial frames are lost.
- Arithmetic: pure storage, no rounding; `frame_cnt` saturates at NFRAME.

Test Plan:
- Single frame: real beat lanes = k, imag beat lanes = 0x0100+k, `out_ready` = 1.
  - Expect `out_valid` 2 cycles after the imag beat.
  - Expect 16 beats with `out_re` = k, `out_im` = 0x0100+k, `out_idx` = k, `out_last` only at k = 15.
  - Expect `frame_cnt` = 1.
- Backpressure: same frame, `out_ready` toggling 1,0,0,1…
  - Outputs hold during stalls; all 16 points arrive in order with no duplicates.
- Ping-pong: three back-to-back frames (6 consecutive beats), `out_ready` = 1.
  - Frames 0 and 1 are buffered; frame 2's real beat hits a full slot.
  - Expect `overflow` = 1, frame 2 dropped, frames 0 and 1 emitted intact, `frame_cnt` = 2.
  - A subsequent frame 3 is captured correctly, proving pairing realignment.
- Gap tolerance: 5 idle cycles between real and imag beats, and between frames.
  - Outputs identical to the back-to-back case.
- Run completion: 64 frames with the 2048-value golden pattern, `out_ready` = 1, `done` after the last imag beat.
  - All 1024 complex points match; `all_done` = 1 after the final `out_last` handshake; `frame_cnt` = 64.
- Reset mid-run: drive `rst` low during SEND at `out_idx` = 7.
  - All outputs go to 0 asynchronously; after release the next full frame is emitted from `out_idx` = 0 with `frame_cnt` restarted at 0.
